// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with a pending-write scoreboard.
// Register 0 reads as zero and is never busy. Each register owns its own
// write-port resolution and busy bit; read ports optionally forward
// same-cycle write data ahead of the stored value.
module regfile_mp #(
  parameter int XLEN   = 64,
  parameter int NREG   = 32,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NWR-1:0]       w_ena,
  input  logic [NWR*AW-1:0]    w_addr,
  input  logic [NWR*XLEN-1:0]  w_data,
  input  logic [NRD-1:0]       r_ena,
  input  logic [NRD*AW-1:0]    r_addr,
  output logic [NRD*XLEN-1:0]  r_data,
  output logic [NRD-1:0]       r_ready,
  input  logic                 alloc_ena,
  input  logic [AW-1:0]        alloc_addr,
  input  logic                 flush,
  output logic [NREG-1:0]      busy_o,
  output logic [NREG*XLEN-1:0] regs_o
);

  // Stored register values gathered into one array so read ports can index it.
  logic [XLEN-1:0] regs_view [NREG];

  genvar gi;

  generate
    for (gi = 0; gi < NREG; gi++) begin : g_reg
      if (gi == 0) begin : g_zero
        assign regs_view[gi] = '0;
        assign busy_o[gi]    = 1'b0;
      end else begin : g_live
        logic [XLEN-1:0] val_reg;
        logic [XLEN-1:0] val_next;
        logic            busy_reg;
        logic            busy_next;
        logic            wr_hit;

        // Resolve all write ports aimed at this register; later ports override earlier ones.
        always_comb begin
          wr_hit   = 1'b0;
          val_next = val_reg;
          for (int i = 0; i < NWR; i++) begin
            if (w_ena[i] && (w_addr[i*AW +: AW] == AW'(gi))) begin
              wr_hit   = 1'b1;
              val_next = w_data[i*XLEN +: XLEN];
            end
          end
        end

        // Scoreboard next state: flush beats alloc, and a new producer beats an old writeback.
        always_comb begin
          busy_next = busy_reg;
          if (flush) begin
            busy_next = 1'b0;
          end else if (alloc_ena && (alloc_addr == AW'(gi))) begin
            busy_next = 1'b1;
          end else if (wr_hit) begin
            busy_next = 1'b0;
          end
        end

        // Register and busy-bit storage with synchronous reset.
        always_ff @(posedge clk) begin
          if (rst) begin
            val_reg  <= '0;
            busy_reg <= 1'b0;
          end else begin
            val_reg  <= val_next;
            busy_reg <= busy_next;
          end
        end

        assign regs_view[gi] = val_reg;
        assign busy_o[gi]    = busy_reg;
      end

      assign regs_o[gi*XLEN +: XLEN] = regs_view[gi];
    end
  endgenerate

  generate
    for (gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0]   addr;
      logic            fwd_hit;
      logic [XLEN-1:0] fwd_data;
      logic [XLEN-1:0] data_next;
      logic            ready_next;

      assign addr = r_addr[gi*AW +: AW];

      // Forwarding lookup: highest-indexed enabled write port with a matching address.
      always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        if (BYPASS != 0) begin
          for (int i = 0; i < NWR; i++) begin
            if (w_ena[i] && (w_addr[i*AW +: AW] == addr)) begin
              fwd_hit  = 1'b1;
              fwd_data = w_data[i*XLEN +: XLEN];
            end
          end
        end
      end

      // Operand data and readiness; reset and disabled ports read as zero.
      always_comb begin
        data_next  = '0;
        ready_next = 1'b0;
        if (!rst) begin
          if (!r_ena[gi] || (addr == '0)) begin
            ready_next = 1'b1;
          end else if (fwd_hit) begin
            data_next  = fwd_data;
            ready_next = 1'b1;
          end else begin
            data_next  = regs_view[addr];
            ready_next = !busy_o[addr];
          end
        end
      end

      assign r_data[gi*XLEN +: XLEN] = data_next;
      assign r_ready[gi]             = ready_next;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives one BYPASS=1 and one BYPASS=0 instance with the same
// directed stimulus, checks every cycle against an array-based model, and
// pins the model with hand-computed literal expectations.
module tb_regfile_mp;
  localparam int XLEN = 64;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NWR-1:0]       w_ena;
  logic [NWR*AW-1:0]    w_addr;
  logic [NWR*XLEN-1:0]  w_data;
  logic [NRD-1:0]       r_ena;
  logic [NRD*AW-1:0]    r_addr;
  logic                 alloc_ena;
  logic [AW-1:0]        alloc_addr;
  logic                 flush;

  logic [NRD*XLEN-1:0]  r_data_b, r_data_n;
  logic [NRD-1:0]       r_ready_b, r_ready_n;
  logic [NREG-1:0]      busy_o_b, busy_o_n;
  logic [NREG*XLEN-1:0] regs_o_b, regs_o_n;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(1)) u_byp (
    .clk(clk), .rst(rst), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
    .r_ena(r_ena), .r_addr(r_addr), .r_data(r_data_b), .r_ready(r_ready_b),
    .alloc_ena(alloc_ena), .alloc_addr(alloc_addr), .flush(flush),
    .busy_o(busy_o_b), .regs_o(regs_o_b)
  );

  regfile_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .BYPASS(0)) u_nob (
    .clk(clk), .rst(rst), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
    .r_ena(r_ena), .r_addr(r_addr), .r_data(r_data_n), .r_ready(r_ready_n),
    .alloc_ena(alloc_ena), .alloc_addr(alloc_addr), .flush(flush),
    .busy_o(busy_o_n), .regs_o(regs_o_n)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [63:0] m_regs [NREG];
  logic [31:0] m_busy;
  bit          m_valid = 1'b0;

  initial begin
    for (int k = 0; k < NREG; k++) m_regs[k] = '0;
    m_busy = '0;
  end

  function automatic logic [63:0] exp_rd(input bit byp, input int j);
    int a;
    a = int'(r_addr[j*AW +: AW]);
    if (rst || !r_ena[j] || a == 0) return 64'd0;
    if (byp) begin
      for (int i = NWR - 1; i >= 0; i--)
        if (w_ena[i] && int'(w_addr[i*AW +: AW]) == a) return w_data[i*XLEN +: XLEN];
    end
    return m_regs[a];
  endfunction

  function automatic logic exp_rdy(input bit byp, input int j);
    int a;
    a = int'(r_addr[j*AW +: AW]);
    if (rst) return 1'b0;
    if (!r_ena[j] || a == 0) return 1'b1;
    if (byp) begin
      for (int i = 0; i < NWR; i++)
        if (w_ena[i] && int'(w_addr[i*AW +: AW]) == a) return 1'b1;
    end
    return !m_busy[a];
  endfunction

  // Every cycle: compare outputs against the model, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    int bad_b, bad_n;
    if (!m_valid && rst) m_valid = 1'b1;
    if (m_valid) begin
      for (int j = 0; j < NRD; j++) begin
        chk($sformatf("model_rdata_byp_p%0d", j), r_data_b[j*XLEN +: XLEN], exp_rd(1'b1, j));
        chk($sformatf("model_rdata_nob_p%0d", j), r_data_n[j*XLEN +: XLEN], exp_rd(1'b0, j));
        chk($sformatf("model_rready_byp_p%0d", j), 64'(r_ready_b[j]), 64'(exp_rdy(1'b1, j)));
        chk($sformatf("model_rready_nob_p%0d", j), 64'(r_ready_n[j]), 64'(exp_rdy(1'b0, j)));
      end
      chk("model_busy_byp", 64'(busy_o_b), 64'(m_busy));
      chk("model_busy_nob", 64'(busy_o_n), 64'(m_busy));
      bad_b = 0;
      bad_n = 0;
      for (int k = NREG - 1; k >= 0; k--) begin
        if (regs_o_b[k*XLEN +: XLEN] !== m_regs[k]) bad_b = k;
        if (regs_o_n[k*XLEN +: XLEN] !== m_regs[k]) bad_n = k;
      end
      chk($sformatf("model_regs_byp_x%0d", bad_b), regs_o_b[bad_b*XLEN +: XLEN], m_regs[bad_b]);
      chk($sformatf("model_regs_nob_x%0d", bad_n), regs_o_n[bad_n*XLEN +: XLEN], m_regs[bad_n]);

      if (rst) begin
        for (int k = 0; k < NREG; k++) m_regs[k] = '0;
        m_busy = '0;
      end else begin
        for (int i = 0; i < NWR; i++)
          if (w_ena[i] && w_addr[i*AW +: AW] != 0)
            m_regs[w_addr[i*AW +: AW]] = w_data[i*XLEN +: XLEN];
        if (flush) begin
          m_busy = '0;
        end else begin
          for (int i = 0; i < NWR; i++)
            if (w_ena[i]) m_busy[w_addr[i*AW +: AW]] = 1'b0;
          if (alloc_ena) m_busy[alloc_addr] = 1'b1;
        end
        m_busy[0] = 1'b0;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    w_ena = '0; w_addr = '0; w_data = '0;
    r_ena = '0; r_addr = '0;
    alloc_ena = 1'b0; alloc_addr = '0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int p, input int a, input logic [63:0] d);
    w_ena[p] = 1'b1;
    w_addr[p*AW +: AW] = 5'(a);
    w_data[p*XLEN +: XLEN] = d;
  endtask

  task automatic rd(input int p, input int a);
    r_ena[p] = 1'b1;
    r_addr[p*AW +: AW] = 5'(a);
  endtask

  task automatic alloc(input int a);
    alloc_ena = 1'b1;
    alloc_addr = 5'(a);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    idle();
    @(posedge clk);
    @(posedge clk);
    #1;
    rd(0, 5); rd(1, 0);
    #1;
    chk("rst_busy", 64'(busy_o_b), 64'd0);
    chk("rst_regs_zero", 64'(regs_o_b == '0), 64'd1);
    chk("rst_rdata_p0", r_data_b[63:0], 64'd0);
    chk("rst_rready", 64'(r_ready_b), 64'd0);

    // Write to x0 is discarded; reading x0 gives 0 and is ready.
    rst = 1'b0;
    idle(); wr(0, 0, 64'hDEAD); rd(0, 0);
    #1;
    chk("x0_rdata", r_data_b[63:0], 64'd0);
    chk("x0_rready", 64'(r_ready_b[0]), 64'd1);
    tick(); idle();
    #1;
    chk("x0_regs_zero", 64'(regs_o_b == '0), 64'd1);

    // Dual write to x5: port 1 wins, forwarded only with bypass.
    wr(0, 5, 64'h11); wr(1, 5, 64'h22); rd(0, 5);
    #1;
    chk("dual_fwd_byp", r_data_b[63:0], 64'h22);
    chk("dual_old_nob", r_data_n[63:0], 64'h0);
    chk("dual_rdy_nob", 64'(r_ready_n[0]), 64'd1);
    tick(); idle(); rd(0, 5);
    #1;
    chk("dual_next_nob", r_data_n[63:0], 64'h22);
    chk("dual_regs_x5", regs_o_b[5*XLEN +: XLEN], 64'h22);

    // Scoreboard life cycle on x7.
    idle(); alloc(7);
    tick(); idle(); rd(1, 7);
    #1;
    chk("sb_busy7", 64'(busy_o_b[7]), 64'd1);
    chk("sb_rdy_byp", 64'(r_ready_b[1]), 64'd0);
    chk("sb_rdy_nob", 64'(r_ready_n[1]), 64'd0);
    wr(0, 7, 64'h55);
    #1;
    chk("sb_wb_rdy_byp", 64'(r_ready_b[1]), 64'd1);
    chk("sb_wb_data_byp", r_data_b[127:64], 64'h55);
    chk("sb_wb_rdy_nob", 64'(r_ready_n[1]), 64'd0);
    tick(); idle();
    #1;
    chk("sb_busy7_clear", 64'(busy_o_b[7]), 64'd0);

    // Alloc/writeback collision on x9: alloc wins, data still lands.
    alloc(9);
    tick(); idle(); wr(0, 9, 64'h3); alloc(9);
    tick(); idle();
    #1;
    chk("coll_busy9", 64'(busy_o_b[9]), 64'd1);
    chk("coll_regs9", regs_o_b[9*XLEN +: XLEN], 64'h3);
    wr(1, 9, 64'h4);
    tick(); idle();
    #1;
    chk("coll_busy9_clear", 64'(busy_o_b[9]), 64'd0);

    // Flush with a same-cycle alloc.
    for (int a = 1; a <= 3; a++) begin
      idle(); alloc(a);
      tick();
    end
    idle();
    #1;
    chk("flush_pre", 64'(busy_o_b[3:0]), 64'hE);
    flush = 1'b1; alloc(4);
    tick(); idle();
    #1;
    chk("flush_busy_byp", 64'(busy_o_b), 64'd0);
    chk("flush_busy_nob", 64'(busy_o_n), 64'd0);

    // Reset mid-operation overrides a write to x12.
    wr(0, 10, 64'hABCD); alloc(11);
    tick(); idle();
    #1;
    chk("mid_regs10", regs_o_b[10*XLEN +: XLEN], 64'hABCD);
    chk("mid_busy11", 64'(busy_o_b[11]), 64'd1);
    rst = 1'b1; wr(0, 12, 64'h77); rd(0, 10);
    #1;
    chk("mid_rst_rdata", r_data_b[63:0], 64'd0);
    chk("mid_rst_rready", 64'(r_ready_b[0]), 64'd0);
    tick(); idle(); rst = 1'b0;
    #1;
    chk("mid_regs_zero", 64'(regs_o_b == '0), 64'd1);
    chk("mid_busy_zero", 64'(busy_o_b), 64'd0);
    chk("mid_regs12", regs_o_b[12*XLEN +: XLEN], 64'd0);

    // Mixed directed traffic checked by the model every cycle.
    for (int c = 0; c < 48; c++) begin
      idle();
      if (c % 3 == 0) wr(0, (c * 7) % 32, 64'(c) * 64'h1111);
      if (c % 4 == 1) wr(1, (c * 5) % 32, ~64'(c));
      if (c % 8 == 3) wr(1, (c * 7) % 32, 64'hC0DE_0000 + 64'(c));
      if (c % 5 == 2) alloc((c * 3) % 32);
      if (c == 30) flush = 1'b1;
      rd(0, (c * 7) % 32);
      if (c % 6 != 5) rd(1, (c * 11) % 32);
      tick();
    end
    idle();
    tick();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total simulation time.
  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
